instr_sram_arbiter: RTL and testbench
=====================================

Name: instr_sram_arbiter

Overview:
- Shares the single-port synchronous instruction SRAM between two requesters: the IF-stage fetch port (read-only) and a program-loader/debug port (read/write, e.g. boot download).
- Sits between IF, the loader and instr_ram, and replaces IF's direct SRAM connection.
- Arbitration is loader-priority, with a starvation guard that forces a fetch slot after a bounded loader burst.
- Read data returns one cycle after the grant and is steered to the owner of that grant.

Parameters:
ADDR_W, 32, SRAM address width (byte address, passed through unchanged)
DATA_W, 32, SRAM data width
MAX_LD_BURST, 8, max consecutive loader grants while fetch is waiting (legal range 1..255)

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
fs_req  input  1  fetch read request; held until fs_gnt
fs_addr  input  ADDR_W  fetch address
fs_gnt  output  1  fetch request accepted this cycle
fs_rvalid  output  1  fetch read data valid
fs_rdata  output  DATA_W  fetch read data
ld_req  input  1  loader request; held until ld_gnt
ld_we  input  1  loader write (1) / read (0)
ld_addr  input  ADDR_W  loader address
ld_wdata  input  DATA_W  loader write data
ld_gnt  output  1  loader request accepted this cycle
ld_rvalid  output  1  loader read data valid
ld_rdata  output  DATA_W  loader read data
instr_sram_en  output  1  SRAM enable
instr_sram_we  output  1  SRAM write enable
instr_sram_addr  output  ADDR_W  SRAM address
instr_sram_wdata  output  DATA_W  SRAM write data
instr  input  DATA_W  SRAM read data, valid the cycle after en with we=0

Behaviour:
- Reset (reset=0, async): state=ST_LDPRI, burst_cnt=0, rsp_pending=0, rsp_owner=FS. All outputs are 0 while reset is low. Any in-flight response is dropped and no rvalid follows release.
- At most one grant per cycle. A grant is combinational from req and state. On the grant cycle: instr_sram_en=1, and addr/we/wdata are muxed from the winner. With no grant: en=0, we=0, addr=0, wdata=0.
- States:
  - ST_LDPRI: ld_req wins if both request.
  - ST_FSSLOT: fs_req wins if both request.
- Transitions:
  - ST_LDPRI, ld granted while fs_req=1: burst_cnt++. When burst_cnt reaches MAX_LD_BURST-1 on that grant, go to ST_FSSLOT and clear burst_cnt.
  - ST_LDPRI, fs_req=0: burst_cnt clears.
  - ST_FSSLOT: a fetch grant returns to ST_LDPRI.
  - ST_FSSLOT with fs_req dropped (e.g. flush): return to ST_LDPRI without a grant. ld_req alone is still granted in that cycle.
- Only one requester active: it is granted every cycle, in either state.
- Read response:
  - A read grant sets rsp_pending=1 and rsp_owner=winner for the next cycle. A write grant sets rsp_pending=0.
  - Next cycle: fs_rvalid = rsp_pending & owner==FS; ld_rvalid = rsp_pending & owner==LD.
  - {fs,ld}_rdata = instr when the matching rvalid is high, else 0.
- Back-to-back reads sustain 1 grant/cycle (pipelined). Responses stay in grant order because latency is fixed at 1.
- Write followed by a read of the same address on the next cycle returns the new data (SRAM ordering; no forwarding needed).
- Requesters must hold req/addr/data stable until gnt. Dropping req before gnt is legal; the request is simply not served.

Decomposition:
- Shared header pipeline.vh:
  - state encodings ST_LDPRI/ST_FSSLOT
  - owner encodings OWN_FS/OWN_LD
  - INSTR_ADDR_W/INSTR_DATA_W defaults
- Sub-module sram_rsp_router: one-deep response tracker (rsp_pending, rsp_owner, rvalid/rdata steering).
- Arbitration FSM and burst counter stay in the top-level block.

Test Plan:
- Reset release, only fs_req=1 with addr 0x0,0x4,0x8 -> fs_gnt high 3 consecutive cycles, fs_rvalid high 3 cycles starting 1 cycle later, fs_rdata = preloaded words; ld_* stay 0.
- Both fs_req and ld_req (writes 0x100..) held continuously with MAX_LD_BURST=8 -> 8 ld_gnt then 1 fs_gnt, repeating pattern 8:1; no cycle with both grants.
- Loader write 0xDEADBEEF to 0x40, then loader read 0x40 next cycle -> ld_rvalid with ld_rdata=0xDEADBEEF; fs_rvalid=0.
- Alternating grants LD-read, FS-read, LD-read -> rvalid routed LD, FS, LD on the following cycles with the correct data; the other port's rdata=0.
- Enter ST_FSSLOT, then drop fs_req -> next cycle state=ST_LDPRI, ld granted, no fs_gnt.
- Assert reset mid-read (grant issued, reset low before the next edge) -> all outputs 0 immediately; after release, no stray rvalid and burst_cnt=0.

Source files
------------

// File: rtl/instr_sram_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// instr_sram_arbiter_pkg
// Shared definitions for the instruction SRAM arbiter:
//   - default address/data widths of the instruction SRAM
//   - arbitration state encodings (ST_LDPRI / ST_FSSLOT)
//   - response owner encodings (OWN_FS / OWN_LD)
//   - width of the loader burst counter and its limit helper
// ---------------------------------------------------------------------------
package instr_sram_arbiter_pkg;

   localparam int INSTR_ADDR_W = 32;
   localparam int INSTR_DATA_W = 32;

   // Wide enough for the largest legal loader burst (255).
   localparam int BURST_CNT_W  = 8;

   typedef enum logic {
      ST_LDPRI  = 1'b0,   // loader wins a simultaneous request
      ST_FSSLOT = 1'b1    // fetch wins a simultaneous request
   } arb_state_e;

   typedef enum logic {
      OWN_FS = 1'b0,
      OWN_LD = 1'b1
   } owner_e;

   // True on the loader grant that completes a burst of max_burst grants.
   // ">=" keeps the FSM safe should the counter ever hold an out-of-range value.
   function automatic logic burst_limit_hit(input logic [BURST_CNT_W-1:0] cnt,
                                            input int unsigned            max_burst);
      logic [BURST_CNT_W-1:0] last;
      last = BURST_CNT_W'(max_burst - 32'd1);
      return (cnt >= last);
   endfunction

endpackage

// File: rtl/instr_sram_arbiter_if.sv
// ---------------------------------------------------------------------------
// instr_sram_arbiter_if
// Requester-side bus of the instruction SRAM arbiter.
//   fetch  : fs_req/fs_addr in, fs_gnt/fs_rvalid/fs_rdata out (read-only)
//   loader : ld_req/ld_we/ld_addr/ld_wdata in, ld_gnt/ld_rvalid/ld_rdata out
// Modports:
//   master : the requesters (IF stage and program loader)
//   slave  : the arbiter
// ---------------------------------------------------------------------------
interface instr_sram_arbiter_if
   import instr_sram_arbiter_pkg::*;
#(
   parameter int ADDR_W = INSTR_ADDR_W,
   parameter int DATA_W = INSTR_DATA_W
);

   logic              fs_req;
   logic [ADDR_W-1:0] fs_addr;
   logic              fs_gnt;
   logic              fs_rvalid;
   logic [DATA_W-1:0] fs_rdata;

   logic              ld_req;
   logic              ld_we;
   logic [ADDR_W-1:0] ld_addr;
   logic [DATA_W-1:0] ld_wdata;
   logic              ld_gnt;
   logic              ld_rvalid;
   logic [DATA_W-1:0] ld_rdata;

   modport master (
      output fs_req, fs_addr,
      output ld_req, ld_we, ld_addr, ld_wdata,
      input  fs_gnt, fs_rvalid, fs_rdata,
      input  ld_gnt, ld_rvalid, ld_rdata
   );

   modport slave (
      input  fs_req, fs_addr,
      input  ld_req, ld_we, ld_addr, ld_wdata,
      output fs_gnt, fs_rvalid, fs_rdata,
      output ld_gnt, ld_rvalid, ld_rdata
   );

endinterface

// File: rtl/instr_sram_arbiter_sram_rsp_router.sv
// ---------------------------------------------------------------------------
// sram_rsp_router
// One-deep read response tracker. The SRAM returns read data exactly one
// cycle after a read grant, so a single pending flag plus the owner of that
// grant is enough to steer the data back to the right requester.
// Ports:
//   clk, reset           : clock, asynchronous active-low reset
//   rd_gnt               : a read was granted this cycle
//   rd_owner             : which requester won that read
//   instr                : SRAM read data (valid the cycle after rd_gnt)
//   fs_rvalid/fs_rdata   : response to the fetch port
//   ld_rvalid/ld_rdata   : response to the loader port
// ---------------------------------------------------------------------------
module sram_rsp_router
   import instr_sram_arbiter_pkg::*;
#(
   parameter int DATA_W = INSTR_DATA_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              rd_gnt,
   input  owner_e            rd_owner,
   input  logic [DATA_W-1:0] instr,
   output logic              fs_rvalid,
   output logic [DATA_W-1:0] fs_rdata,
   output logic              ld_rvalid,
   output logic [DATA_W-1:0] ld_rdata
);

   logic   rsp_pending_r;
   owner_e rsp_owner_r;

   // Track the read issued this cycle; reset drops any in-flight response.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rsp_pending_r <= 1'b0;
         rsp_owner_r   <= OWN_FS;
      end else begin
         rsp_pending_r <= rd_gnt;
         if (rd_gnt) begin
            rsp_owner_r <= rd_owner;
         end
      end
   end

   // Steer SRAM data to the owner of the pending read; the idle port sees 0.
   always_comb begin
      fs_rvalid = rsp_pending_r && (rsp_owner_r == OWN_FS);
      ld_rvalid = rsp_pending_r && (rsp_owner_r == OWN_LD);
      if (fs_rvalid) begin
         fs_rdata = instr;
      end else begin
         fs_rdata = '0;
      end
      if (ld_rvalid) begin
         ld_rdata = instr;
      end else begin
         ld_rdata = '0;
      end
   end

endmodule

// File: rtl/instr_sram_arbiter.sv
// ---------------------------------------------------------------------------
// instr_sram_arbiter
// Shares the single-port instruction SRAM between the IF-stage fetch port
// (read-only) and the program-loader/debug port (read/write). The loader has
// priority, but after MAX_LD_BURST consecutive loader grants with fetch
// waiting, one slot is reserved for fetch.
// Ports:
//   clk, reset        : clock, asynchronous active-low reset
//   bus (slave)       : fetch and loader request/grant/response signals
//   instr_sram_*      : SRAM command (en/we/addr/wdata), zero when idle
//   instr             : SRAM read data, one cycle after a read command
// ---------------------------------------------------------------------------
module instr_sram_arbiter
   import instr_sram_arbiter_pkg::*;
#(
   parameter int ADDR_W       = INSTR_ADDR_W,
   parameter int DATA_W       = INSTR_DATA_W,
   parameter int MAX_LD_BURST = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   instr_sram_arbiter_if.slave  bus,
   output logic                 instr_sram_en,
   output logic                 instr_sram_we,
   output logic [ADDR_W-1:0]    instr_sram_addr,
   output logic [DATA_W-1:0]    instr_sram_wdata,
   input  logic [DATA_W-1:0]    instr
);

   arb_state_e             state_r;
   logic [BURST_CNT_W-1:0] burst_cnt_r;
   logic                   fs_gnt_s;
   logic                   ld_gnt_s;
   logic                   rd_gnt_s;
   owner_e                 rd_owner_s;

   // Grant selection; gated by reset so every output is 0 while reset is low.
   always_comb begin
      fs_gnt_s = 1'b0;
      ld_gnt_s = 1'b0;
      if (!reset) begin
         fs_gnt_s = 1'b0;
         ld_gnt_s = 1'b0;
      end else if (bus.fs_req && bus.ld_req) begin
         if (state_r == ST_FSSLOT) begin
            fs_gnt_s = 1'b1;
         end else begin
            ld_gnt_s = 1'b1;
         end
      end else if (bus.ld_req) begin
         ld_gnt_s = 1'b1;
      end else if (bus.fs_req) begin
         fs_gnt_s = 1'b1;
      end else begin
         fs_gnt_s = 1'b0;
         ld_gnt_s = 1'b0;
      end
   end

   // SRAM command mux from the winner; all-zero when nothing is granted.
   always_comb begin
      instr_sram_en    = fs_gnt_s | ld_gnt_s;
      instr_sram_we    = 1'b0;
      instr_sram_addr  = '0;
      instr_sram_wdata = '0;
      if (ld_gnt_s) begin
         instr_sram_we    = bus.ld_we;
         instr_sram_addr  = bus.ld_addr;
         instr_sram_wdata = bus.ld_wdata;
      end else if (fs_gnt_s) begin
         instr_sram_addr  = bus.fs_addr;
      end else begin
         instr_sram_addr  = '0;
      end
   end

   // Arbitration FSM with the starvation-guard burst counter.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r     <= ST_LDPRI;
         burst_cnt_r <= '0;
      end else begin
         case (state_r)
            ST_LDPRI: begin
               if (!bus.fs_req) begin
                  // Fetch not waiting: nothing to guard against.
                  burst_cnt_r <= '0;
               end else if (ld_gnt_s) begin
                  if (burst_limit_hit(burst_cnt_r, MAX_LD_BURST)) begin
                     state_r     <= ST_FSSLOT;
                     burst_cnt_r <= '0;
                  end else begin
                     burst_cnt_r <= burst_cnt_r + 1'b1;
                  end
               end
            end
            ST_FSSLOT: begin
               // Left after one cycle: either fetch is granted, or it
               // withdrew its request and the slot is abandoned.
               state_r     <= ST_LDPRI;
               burst_cnt_r <= '0;
            end
            default: begin
               state_r     <= ST_LDPRI;
               burst_cnt_r <= '0;
            end
         endcase
      end
   end

   assign rd_gnt_s   = (fs_gnt_s | ld_gnt_s) & ~(ld_gnt_s & bus.ld_we);
   assign rd_owner_s = ld_gnt_s ? OWN_LD : OWN_FS;

   assign bus.fs_gnt = fs_gnt_s;
   assign bus.ld_gnt = ld_gnt_s;

   sram_rsp_router #(
      .DATA_W (DATA_W)
   ) u_rsp_router (
      .clk       (clk),
      .reset     (reset),
      .rd_gnt    (rd_gnt_s),
      .rd_owner  (rd_owner_s),
      .instr     (instr),
      .fs_rvalid (bus.fs_rvalid),
      .fs_rdata  (bus.fs_rdata),
      .ld_rvalid (bus.ld_rvalid),
      .ld_rdata  (bus.ld_rdata)
   );

endmodule

// File: tb/tb_instr_sram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_instr_sram_arbiter
// Self-checking bench: a behavioural SRAM, a table of per-cycle vectors with
// expected grants, a reference memory and a response queue holding the read
// data each grant must return one cycle later.
// ---------------------------------------------------------------------------
module tb_instr_sram_arbiter;
   import instr_sram_arbiter_pkg::*;

   localparam int AW   = 32;
   localparam int DW   = 32;
   localparam int MAXB = 8;

   typedef struct packed {
      logic          fs_req;
      logic [AW-1:0] fs_addr;
      logic          ld_req;
      logic          ld_we;
      logic [AW-1:0] ld_addr;
      logic [DW-1:0] ld_wdata;
      logic          exp_fs;
      logic          exp_ld;
   } vec_t;

   typedef struct packed {
      logic          valid;
      owner_e        owner;
      logic [DW-1:0] data;
   } rsp_t;

   logic          clk = 1'b0;
   logic          reset;
   logic          sram_en;
   logic          sram_we;
   logic [AW-1:0] sram_addr;
   logic [DW-1:0] sram_wdata;
   logic [DW-1:0] instr;

   int tests_run    = 0;
   int tests_failed = 0;

   rsp_t sb_q[$];

   always #5 clk = ~clk;

   instr_sram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   instr_sram_arbiter #(
      .ADDR_W       (AW),
      .DATA_W       (DW),
      .MAX_LD_BURST (MAXB)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .bus              (bus),
      .instr_sram_en    (sram_en),
      .instr_sram_we    (sram_we),
      .instr_sram_addr  (sram_addr),
      .instr_sram_wdata (sram_wdata),
      .instr            (instr)
   );

   function automatic logic [DW-1:0] init_word(input logic [7:0] idx);
      return 32'hC0DE_0000 | {24'h0, idx};
   endfunction

   // Behavioural SRAM: unwritten words read back their preload pattern.
   logic [DW-1:0] mem [0:255];
   logic [255:0]  written = '0;
   logic [7:0]    sram_idx;
   assign sram_idx = sram_addr[9:2];

   always @(posedge clk) begin
      if (sram_en) begin
         if (sram_we) begin
            mem[sram_idx]     <= sram_wdata;
            written[sram_idx] <= 1'b1;
         end else begin
            instr <= written[sram_idx] ? mem[sram_idx] : init_word(sram_idx);
         end
      end
   end

   // Reference memory updated from the bench's own expected grants.
   logic [DW-1:0] ref_mem [0:255];
   logic [255:0]  ref_written = '0;

   function automatic logic [DW-1:0] ref_read(input logic [AW-1:0] a);
      logic [7:0] i;
      i = a[9:2];
      return ref_written[i] ? ref_mem[i] : init_word(i);
   endfunction

   function automatic vec_t mk(input logic fr, input logic [AW-1:0] fa,
                               input logic lr, input logic lw,
                               input logic [AW-1:0] la, input logic [DW-1:0] lwd,
                               input logic ef, input logic el);
      vec_t v;
      v.fs_req = fr; v.fs_addr = fa; v.ld_req = lr; v.ld_we = lw;
      v.ld_addr = la; v.ld_wdata = lwd; v.exp_fs = ef; v.exp_ld = el;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      bus.fs_req   = v.fs_req;
      bus.fs_addr  = v.fs_addr;
      bus.ld_req   = v.ld_req;
      bus.ld_we    = v.ld_we;
      bus.ld_addr  = v.ld_addr;
      bus.ld_wdata = v.ld_wdata;
   endtask

   task automatic check_all_zero(input string name);
      check({name, "/fs_gnt"},    32'(bus.fs_gnt),    32'h0);
      check({name, "/ld_gnt"},    32'(bus.ld_gnt),    32'h0);
      check({name, "/fs_rvalid"}, 32'(bus.fs_rvalid), 32'h0);
      check({name, "/ld_rvalid"}, 32'(bus.ld_rvalid), 32'h0);
      check({name, "/fs_rdata"},  bus.fs_rdata,       32'h0);
      check({name, "/ld_rdata"},  bus.ld_rdata,       32'h0);
      check({name, "/en"},        32'(sram_en),       32'h0);
      check({name, "/we"},        32'(sram_we),       32'h0);
      check({name, "/addr"},      sram_addr,          32'h0);
      check({name, "/wdata"},     sram_wdata,         32'h0);
   endtask

   // One cycle: drive at negedge, check last cycle's response and this
   // cycle's grant/SRAM command, then queue the response this grant implies.
   task automatic step(input vec_t v, input string name);
      rsp_t          r;
      logic [AW-1:0] e_addr;
      logic [DW-1:0] e_wdata;
      @(negedge clk);
      drive(v);
      #1;
      if (sb_q.size() > 0) begin
         r = sb_q.pop_front();
      end else begin
         r = '0;
      end
      check({name, "/fs_rvalid"}, 32'(bus.fs_rvalid), 32'(r.valid && r.owner == OWN_FS));
      check({name, "/ld_rvalid"}, 32'(bus.ld_rvalid), 32'(r.valid && r.owner == OWN_LD));
      check({name, "/fs_rdata"},  bus.fs_rdata, (r.valid && r.owner == OWN_FS) ? r.data : 32'h0);
      check({name, "/ld_rdata"},  bus.ld_rdata, (r.valid && r.owner == OWN_LD) ? r.data : 32'h0);
      e_addr  = v.exp_ld ? v.ld_addr : (v.exp_fs ? v.fs_addr : 32'h0);
      e_wdata = v.exp_ld ? v.ld_wdata : 32'h0;
      check({name, "/fs_gnt"}, 32'(bus.fs_gnt), 32'(v.exp_fs));
      check({name, "/ld_gnt"}, 32'(bus.ld_gnt), 32'(v.exp_ld));
      check({name, "/en"},     32'(sram_en),    32'(v.exp_fs | v.exp_ld));
      check({name, "/we"},     32'(sram_we),    32'(v.exp_ld & v.ld_we));
      check({name, "/addr"},   sram_addr,       e_addr);
      check({name, "/wdata"},  sram_wdata,      e_wdata);
      if (v.exp_ld && v.ld_we) begin
         ref_mem[v.ld_addr[9:2]]     = v.ld_wdata;
         ref_written[v.ld_addr[9:2]] = 1'b1;
      end
      r.valid = (v.exp_fs || v.exp_ld) && !(v.exp_ld && v.ld_we);
      r.owner = v.exp_ld ? OWN_LD : OWN_FS;
      r.data  = ref_read(v.exp_ld ? v.ld_addr : v.fs_addr);
      sb_q.push_back(r);
   endtask

   // Both ports requesting for 'n' cycles; expect 8 loader grants then 1 fetch.
   task automatic burst_run(input int n, input logic [AW-1:0] base, input string name);
      for (int i = 0; i < n; i++) begin
         step(mk(1'b1, 32'h80, 1'b1, 1'b1, base + 32'(4 * i), 32'h1000 + 32'(i),
                 (i % (MAXB + 1)) == MAXB, (i % (MAXB + 1)) != MAXB), name);
      end
   endtask

   vec_t tbl [14];
   vec_t idle_v;

   initial begin
      idle_v  = mk(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      tbl[0]  = mk(1'b1, 32'h00, 1'b0, 1'b0, 32'h0,  32'h0,         1'b1, 1'b0);
      tbl[1]  = mk(1'b1, 32'h04, 1'b0, 1'b0, 32'h0,  32'h0,         1'b1, 1'b0);
      tbl[2]  = mk(1'b1, 32'h08, 1'b0, 1'b0, 32'h0,  32'h0,         1'b1, 1'b0);
      tbl[3]  = idle_v;
      tbl[4]  = mk(1'b0, 32'h00, 1'b1, 1'b1, 32'h40, 32'hDEADBEEF,  1'b0, 1'b1);
      tbl[5]  = mk(1'b0, 32'h00, 1'b1, 1'b0, 32'h40, 32'h0,         1'b0, 1'b1);
      tbl[6]  = idle_v;
      tbl[7]  = mk(1'b0, 32'h00, 1'b1, 1'b0, 32'h10, 32'h0,         1'b0, 1'b1);
      tbl[8]  = mk(1'b1, 32'h20, 1'b0, 1'b0, 32'h0,  32'h0,         1'b1, 1'b0);
      tbl[9]  = mk(1'b0, 32'h00, 1'b1, 1'b0, 32'h40, 32'h0,         1'b0, 1'b1);
      tbl[10] = idle_v;
      tbl[11] = mk(1'b1, 32'h24, 1'b1, 1'b0, 32'h44, 32'h0,         1'b0, 1'b1);
      tbl[12] = mk(1'b1, 32'h24, 1'b0, 1'b0, 32'h0,  32'h0,         1'b1, 1'b0);
      tbl[13] = idle_v;

      // Reset with both ports requesting: everything must stay at 0.
      reset = 1'b0;
      drive(mk(1'b1, 32'h4, 1'b1, 1'b1, 32'h8, 32'h1234, 1'b0, 1'b0));
      #2;
      check_all_zero("reset");
      @(posedge clk);
      @(negedge clk);
      drive(idle_v);
      reset = 1'b1;

      foreach (tbl[i]) begin
         step(tbl[i], $sformatf("vec%0d", i));
      end

      // Sustained contention: 8:1 pattern, never both grants.
      burst_run(2 * (MAXB + 1), 32'h100, "burst");
      step(idle_v, "burst_idle");

      // Enter the fetch slot, then fetch withdraws: loader served, back to LDPRI.
      burst_run(MAXB, 32'h200, "to_fsslot");
      step(mk(1'b0, 32'h0, 1'b1, 1'b0, 32'h100, 32'h0, 1'b0, 1'b1), "fsslot_drop");
      burst_run(MAXB + 1, 32'h300, "after_drop");
      step(idle_v, "drop_idle");

      // Reset during a read: partial burst, fetch read granted, then reset.
      burst_run(3, 32'h380, "pre_reset");
      step(mk(1'b1, 32'h8, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0), "read_before_reset");
      reset = 1'b0;
      #1;
      check_all_zero("reset_mid");
      sb_q.delete();
      @(negedge clk);
      drive(idle_v);
      reset = 1'b1;
      step(idle_v, "post_reset");
      burst_run(MAXB + 1, 32'h3C0, "post_reset_burst");
      step(idle_v, "final_idle");

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
